// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared types and constants for the (N,Q) sequential divider.
// QDIV_ROUND_EN adds one guard iteration for round-to-nearest.
package qdiv_pkg;
   localparam int QDIV_Q = 15;
   localparam int QDIV_N = 32;
   localparam logic [QDIV_N-2:0] QDIV_SAT = '1;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } qdiv_state_e;

   function automatic int qdiv_iter(input int n, input int q);
`ifdef QDIV_ROUND_EN
      return n + q;
`else
      return n - 1 + q;
`endif
   endfunction

   function automatic int qdiv_lat(input int n, input int q);
      return qdiv_iter(n, q) + 1;
   endfunction
endpackage

// File: rtl/qdiv_if.sv
// qdiv_if: start/operand request and busy/done/result response of qdiv_seq.
// master drives the request; slave is the divider.
interface qdiv_if
   import qdiv_pkg::*;
#(
   parameter int N = QDIV_N
);
   logic         i_start;
   logic [N-1:0] i_dividend;
   logic [N-1:0] i_divisor;
   logic         o_busy;
   logic         o_done;
   logic [N-1:0] o_result;
   logic         o_ovr;
   logic         o_dbz;

   modport master (
      output i_start, i_dividend, i_divisor,
      input  o_busy, o_done, o_result, o_ovr, o_dbz
   );

   modport slave (
      input  i_start, i_dividend, i_divisor,
      output o_busy, o_done, o_result, o_ovr, o_dbz
   );
endinterface

// File: rtl/qdiv_step.sv
// qdiv_step: one restoring shift/compare/subtract iteration.
// Remainder stays below the divisor, so the shifted value fits N bits.
module qdiv_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] rem_i,
   input  logic         bit_i,
   input  logic [N-2:0] div_i,
   output logic [N-1:0] rem_o,
   output logic         q_o
);
   logic [N-1:0] shifted;
   logic [N-1:0] div_ext;

   assign shifted = {rem_i[N-2:0], bit_i};
   assign div_ext = {1'b0, div_i};
   assign q_o     = (shifted >= div_ext);
   assign rem_o   = q_o ? (shifted - div_ext) : shifted;
endmodule

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential sign-magnitude (N,Q) restoring divider, one bit/clock.
// QDIV_ROUND_EN adds a guard iteration and rounds the magnitude half-up.
module qdiv_seq
   import qdiv_pkg::*;
#(
   parameter int Q = QDIV_Q,
   parameter int N = QDIV_N
) (
   input logic   i_clk,
   input logic   i_rst_n,
   qdiv_if.slave bus
);
   localparam int ITER = qdiv_iter(N, Q);
   localparam int G    = ITER - (N - 1 + Q);
   localparam int CW   = $clog2(ITER + 1);

   qdiv_state_e   state_q;
   logic [CW-1:0] cnt_q;
   logic [ITER-1:0] num_q;
   logic [ITER-1:0] quot_q;
   logic [N-1:0]  rem_q;
   logic [N-1:0]  rem_d;
   logic [N-2:0]  div_q;
   logic          sign_q;
   logic          qbit;
   logic          busy_q;
   logic          done_q;
   logic [N-1:0]  res_q;
   logic          ovr_q;
   logic          dbz_q;

   qdiv_step #(.N(N)) u_step (
      .rem_i (rem_q),
      .bit_i (num_q[ITER-1]),
      .div_i (div_q),
      .rem_o (rem_d),
      .q_o   (qbit)
   );

   logic         rnd;
   logic         dbz_d;
   logic         ovr_d;
   logic [N-1:0] sum;
   logic [N-2:0] mag_d;

`ifdef QDIV_ROUND_EN
   assign rnd = quot_q[0];
`else
   assign rnd = 1'b0;
`endif

   // Bits above the N-1 magnitude bits, or a rounding carry, saturate.
   assign sum   = {1'b0, quot_q[N-2+G:G]} + {{(N-1){1'b0}}, rnd};
   assign dbz_d = (div_q == '0);
   assign ovr_d = dbz_d | (|quot_q[ITER-1:N-1+G]) | sum[N-1];
   assign mag_d = ovr_d ? {(N-1){1'b1}} : sum[N-2:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         num_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         sign_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         ovr_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.i_start) begin
                  num_q   <= {bus.i_dividend[N-2:0], {(Q+G){1'b0}}};
                  div_q   <= bus.i_divisor[N-2:0];
                  sign_q  <= bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
                  rem_q   <= '0;
                  quot_q  <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_q == CW'(ITER)) begin
                  res_q   <= {sign_q, mag_d};
                  ovr_q   <= ovr_d;
                  dbz_q   <= dbz_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  rem_q  <= rem_d;
                  num_q  <= {num_q[ITER-2:0], 1'b0};
                  quot_q <= {quot_q[ITER-2:0], qbit};
                  cnt_q  <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.o_busy   = busy_q;
   assign bus.o_done   = done_q;
   assign bus.o_result = res_q;
   assign bus.o_ovr    = ovr_q;
   assign bus.o_dbz    = dbz_q;
endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: scoreboard bench for qdiv_seq (default and QDIV_ROUND_EN).
// Expected results are queued at start and popped on o_done.
module tb_qdiv_seq;
   import qdiv_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic        ovr;
      logic        dbz;
   } exp_t;

`ifdef QDIV_ROUND_EN
   localparam int          LAT   = 48;
   localparam logic [31:0] THIRD = 32'h00002AAB;
`else
   localparam int          LAT   = 47;
   localparam logic [31:0] THIRD = 32'h00002AAA;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_done = 0;
   exp_t sb[$];

   qdiv_if #(.N(32)) bus ();

   qdiv_seq dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic o,
                               input logic z);
      exp_t e;
      e.res = r;
      e.ovr = o;
      e.dbz = z;
      return e;
   endfunction

   function automatic exp_t model(input logic [31:0] a,
                                  input logic [31:0] b);
      longint unsigned ma, mb, q;
      exp_t e;
      ma = 64'(a[30:0]);
      mb = 64'(b[30:0]);
      e.res[31]   = a[31] ^ b[31];
      e.res[30:0] = QDIV_SAT;
      e.dbz = (mb == 0);
      e.ovr = e.dbz;
      if (!e.dbz) begin
`ifdef QDIV_ROUND_EN
         q = (ma << 16) / mb;
         q = (q >> 1) + (q & 64'd1);
`else
         q = (ma << 15) / mb;
`endif
         e.ovr = (q > 64'h7FFF_FFFF);
         if (!e.ovr) e.res[30:0] = q[30:0];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (bus.o_done === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            check("spurious_done", 64'(bus.o_done), 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", 64'(bus.o_result), 64'(e.res));
            check("ovr", 64'(bus.o_ovr), 64'(e.ovr));
            check("dbz", 64'(bus.o_dbz), 64'(e.dbz));
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int poke);
      int lat;
      int d0;
      lat = 0;
      @(negedge clk);
      bus.i_dividend = a;
      bus.i_divisor  = b;
      bus.i_start    = 1'b1;
      sb.push_back(e);
      d0 = n_done;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      for (int c = 1; c <= 200 && lat == 0; c++) begin
         @(posedge clk);
         #1;
         if (c == poke) begin
            bus.i_start    = 1'b1;
            bus.i_dividend = ~a;
            bus.i_divisor  = 32'h0000_0001;
         end else begin
            bus.i_start = 1'b0;
         end
         if (c == 5) check("busy_mid", 64'(bus.o_busy), 1);
         if (bus.o_done === 1'b1) lat = c;
      end
      bus.i_start = 1'b0;
      check("latency", 64'(lat), 64'(LAT));
      check("busy_in_done", 64'(bus.o_busy), 0);
      @(posedge clk);
      #1;
      check("done_pulse", 64'(bus.o_done), 0);
      repeat (3) @(posedge clk);
      #1;
      check("one_done", 64'(n_done - d0), 1);
      check("held", 64'(bus.o_result), 64'(e.res));
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int d0;
      bus.i_start    = 1'b0;
      bus.i_dividend = '0;
      bus.i_divisor  = '0;
      #2;
      check("rst_busy", 64'(bus.o_busy), 0);
      check("rst_done", 64'(bus.o_done), 0);
      check("rst_result", 64'(bus.o_result), 0);
      check("rst_ovr", 64'(bus.o_ovr), 0);
      check("rst_dbz", 64'(bus.o_dbz), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 0, 0), 0);
      run_op(32'h8000_8000, 32'h0000_4000, mk(32'h8001_0000, 0, 0), 0);
      run_op(32'h0000_8000, 32'h8002_0000, mk(32'h8000_2000, 0, 0), 0);
      run_op(32'h0000_8000, 32'h0001_8000, mk(THIRD, 0, 0), 0);
      run_op(32'h0000_8000, 32'h8000_0000, mk(32'hFFFF_FFFF, 1, 1), 0);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, mk(32'h7FFF_FFFF, 1, 0), 0);
      run_op(32'h8000_0000, 32'h0001_0000, mk(32'h8000_0000, 0, 0), 0);

      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = $urandom;
         a[30:20] = '0;
         b[30:18] = '0;
         run_op(a, b, model(a, b), 0);
      end

      run_op(32'h0001_8000, 32'h0001_0000, mk(32'h0000_C000, 0, 0), 10);

      @(negedge clk);
      bus.i_dividend = 32'h0000_8000;
      bus.i_divisor  = 32'h0001_8000;
      bus.i_start    = 1'b1;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      d0 = n_done;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.o_busy), 0);
      check("abort_done", 64'(bus.o_done), 0);
      check("abort_result", 64'(bus.o_result), 0);
      check("abort_ovr", 64'(bus.o_ovr), 0);
      check("abort_dbz", 64'(bus.o_dbz), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(posedge clk);
      #1;
      check("abort_no_done", 64'(n_done - d0), 0);

      run_op(32'h8000_8000, 32'h0000_4000, mk(32'h8001_0000, 0, 0), 0);

      check("sb_empty", 64'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
